// File: rtl/mem_access_unit.sv
// Memory-stage load/store responder: single-beat request/ready bus with byte lanes.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset_stages,
   input  logic              Mem_read,
   input  logic              Mem_write,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              Stall,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   output logic              misaligned,
   output logic              access_fault,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ready,
   input  logic [DATA_W-1:0] bus_rdata
);

   // state | meaning
   // IDLE  | no access outstanding
   // REQ   | bus_req high, waiting for bus_ready
   // DONE  | one cycle, Stall low, results presented, pipeline inputs ignored
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t            state_q;
   logic              bus_req_q, bus_we_q, load_valid_q, misaligned_q, access_fault_q;
   logic [ADDR_W-1:0] bus_addr_q;
   logic [3:0]        bus_be_q;
   logic [DATA_W-1:0] bus_wdata_q, load_data_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;

   logic              req, f3_legal, aligned, start;
   logic [3:0]        be_d;
   logic [DATA_W-1:0] wdata_d, rdata_sh, load_ext;

   assign req = Mem_read | Mem_write;

   always_comb begin
      f3_legal = 1'b0;
      aligned  = 1'b1;
      be_d     = 4'hF;
      if (Mem_write)
         f3_legal = funct3 inside {3'b000, 3'b001, 3'b010};
      else
         f3_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      case (funct3[1:0])
         2'b01:   aligned = ~addr[0];
         2'b10:   aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      // loads always fetch the whole word; lanes matter only for stores
      if (Mem_write) begin
         case (funct3[1:0])
            2'b00:   be_d = 4'b0001 << addr[1:0];
            2'b01:   be_d = 4'b0011 << addr[1:0];
            default: be_d = 4'hF;
         endcase
      end
   end

   assign start   = (state_q == IDLE) && req && f3_legal && aligned;
   assign wdata_d = wdata << {addr[1:0], 3'b000};
   assign Stall   = start || (state_q == REQ);

   assign rdata_sh = bus_rdata >> {off_q, 3'b000};

   always_comb begin
      load_ext = rdata_sh;
      case (f3_q)
         3'b000:  load_ext = {{(DATA_W-8){rdata_sh[7]}}, rdata_sh[7:0]};
         3'b001:  load_ext = {{(DATA_W-16){rdata_sh[15]}}, rdata_sh[15:0]};
         3'b100:  load_ext = {{(DATA_W-8){1'b0}}, rdata_sh[7:0]};
         3'b101:  load_ext = {{(DATA_W-16){1'b0}}, rdata_sh[15:0]};
         default: load_ext = rdata_sh;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q;
`endif

   always_ff @(posedge clk) begin
      if (reset_stages) begin
         state_q        <= IDLE;
         bus_req_q      <= 1'b0;
         bus_we_q       <= 1'b0;
         bus_addr_q     <= '0;
         bus_be_q       <= '0;
         bus_wdata_q    <= '0;
         load_data_q    <= '0;
         load_valid_q   <= 1'b0;
         misaligned_q   <= 1'b0;
         access_fault_q <= 1'b0;
         f3_q           <= '0;
         off_q          <= '0;
`ifdef MEM_TIMEOUT_EN
         wd_q           <= '0;
`endif
      end else begin
         load_valid_q   <= 1'b0;
         misaligned_q   <= 1'b0;
         access_fault_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req) begin
                  if (!f3_legal)
                     access_fault_q <= 1'b1;
                  else if (!aligned)
                     misaligned_q <= 1'b1;
                  else begin
                     bus_req_q   <= 1'b1;
                     bus_we_q    <= Mem_write;
                     bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                     bus_be_q    <= be_d;
                     bus_wdata_q <= wdata_d;
                     f3_q        <= funct3;
                     off_q       <= addr[1:0];
                     state_q     <= REQ;
`ifdef MEM_TIMEOUT_EN
                     wd_q        <= '0;
`endif
                  end
               end
            end
            REQ: begin
               if (bus_ready) begin
                  bus_req_q <= 1'b0;
                  state_q   <= DONE;
                  if (!bus_we_q) begin
                     load_valid_q <= 1'b1;
                     load_data_q  <= load_ext;
                  end
               end
`ifdef MEM_TIMEOUT_EN
               else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  bus_req_q      <= 1'b0;
                  state_q        <= DONE;
                  access_fault_q <= 1'b1;
                  load_data_q    <= '0;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
`endif
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_req      = bus_req_q;
   assign bus_we       = bus_we_q;
   assign bus_addr     = bus_addr_q;
   assign bus_be       = bus_be_q;
   assign bus_wdata    = bus_wdata_q;
   assign load_data    = load_data_q;
   assign load_valid   = load_valid_q;
   assign misaligned   = misaligned_q;
   assign access_fault = access_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus load-data scoreboard.
// Timeout sequence is compiled only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset_stages = 1'b1;
   logic        Mem_read = 1'b0, Mem_write = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic        bus_ready = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic        Stall, load_valid, misaligned, access_fault, bus_req, bus_we;
   logic [31:0] load_data, bus_addr, bus_wdata;
   logic [3:0]  bus_be;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      int          kind;   // 0 bus access, 1 misaligned, 2 access fault
      logic [3:0]  be;
      logic [31:0] bwd;
      logic [31:0] ld;
   } vec_t;

   vec_t tbl[$];

   mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset_stages(reset_stages),
      .Mem_read(Mem_read), .Mem_write(Mem_write), .funct3(funct3),
      .addr(addr), .wdata(wdata), .Stall(Stall),
      .load_data(load_data), .load_valid(load_valid),
      .misaligned(misaligned), .access_fault(access_fault),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ready(bus_ready), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (load_valid === 1'b1) begin
         if (exp_q.size() == 0)
            chk("unexpected load_valid", {31'b0, load_valid}, 32'h0);
         else
            chk("load_data", load_data, exp_q.pop_front());
      end
   end

   // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
   task automatic run_access(input vec_t v);
      int  n_stall = 0;
      int  w = 0;
      bit  done = 0;
      Mem_read  = v.rd;
      Mem_write = v.wr;
      funct3    = v.f3;
      addr      = v.addr;
      wdata     = v.wdata;
      if (v.rd && !v.wr) exp_q.push_back(v.ld);
      for (int c = 0; c < 64; c++) begin
         #1;
         if (!Stall) begin
            done = 1;
            break;
         end
         n_stall++;
         if (bus_req) begin
            chk("bus_addr", bus_addr, {v.addr[31:2], 2'b00});
            chk("bus_be", {28'b0, bus_be}, {28'b0, v.be});
            chk("bus_we", {31'b0, bus_we}, {31'b0, v.wr});
            if (v.wr) chk("bus_wdata", bus_wdata, v.bwd);
            if (w == v.waits) begin
               bus_ready = 1'b1;
               bus_rdata = v.rdata;
            end else begin
               bus_ready = 1'b0;
               bus_rdata = $urandom;
               w++;
            end
         end
         @(negedge clk);
      end
      chk("stall released", {31'b0, done}, 32'h1);
      chk("stall cycles", n_stall, v.waits + 2);
      Mem_read  = 1'b0;
      Mem_write = 1'b0;
      bus_ready = 1'b0;
      @(negedge clk);
      chk("load_valid single pulse", {31'b0, load_valid}, 32'h0);
      chk("bus_req idle", {31'b0, bus_req}, 32'h0);
   endtask

   task automatic run_reject(input vec_t v);
      Mem_read  = v.rd;
      Mem_write = v.wr;
      funct3    = v.f3;
      addr      = v.addr;
      wdata     = v.wdata;
      #1;
      chk("reject stall", {31'b0, Stall}, 32'h0);
      @(negedge clk);
      chk("misaligned pulse", {31'b0, misaligned}, (v.kind == 1) ? 32'h1 : 32'h0);
      chk("fault pulse", {31'b0, access_fault}, (v.kind == 2) ? 32'h1 : 32'h0);
      chk("reject bus_req", {31'b0, bus_req}, 32'h0);
      Mem_read  = 1'b0;
      Mem_write = 1'b0;
      @(negedge clk);
      chk("pulse cleared", {30'b0, misaligned, access_fault}, 32'h0);
   endtask

   initial begin
      //            rd wr f3      addr          wdata         rdata         wt kd be       bwd           ld
      tbl.push_back('{1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'hF,    32'h0,        32'hDEADBEEF});
      tbl.push_back('{1, 0, 3'b000, 32'h203, 32'h0,        32'h80123456, 0, 0, 4'hF,    32'h0,        32'hFFFFFF80});
      tbl.push_back('{1, 0, 3'b100, 32'h203, 32'h0,        32'h80123456, 1, 0, 4'hF,    32'h0,        32'h00000080});
      tbl.push_back('{0, 1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0,        3, 0, 4'b1100, 32'hABCD0000, 32'h0});
      tbl.push_back('{1, 0, 3'b001, 32'h002, 32'h0,        32'h80011234, 0, 0, 4'hF,    32'h0,        32'hFFFF8001});
      tbl.push_back('{1, 0, 3'b101, 32'h002, 32'h0,        32'h80011234, 2, 0, 4'hF,    32'h0,        32'h00008001});
      tbl.push_back('{0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 0, 4'b0010, 32'h0000A500, 32'h0});
      tbl.push_back('{0, 1, 3'b010, 32'h040, 32'h12345678, 32'h0,        1, 0, 4'hF,    32'h12345678, 32'h0});
      tbl.push_back('{1, 0, 3'b000, 32'h000, 32'h0,        32'h0000007F, 0, 0, 4'hF,    32'h0,        32'h0000007F});
      tbl.push_back('{1, 1, 3'b010, 32'h080, 32'hCAFEF00D, 32'h55555555, 0, 0, 4'hF,    32'hCAFEF00D, 32'h0});
      tbl.push_back('{1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1, 4'h0,    32'h0,        32'h0});
      tbl.push_back('{1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 2, 4'h0,    32'h0,        32'h0});
      tbl.push_back('{0, 1, 3'b001, 32'h303, 32'h0,        32'h0,        0, 1, 4'h0,    32'h0,        32'h0});
      tbl.push_back('{0, 1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 2, 4'h0,    32'h0,        32'h0});
      tbl.push_back('{1, 0, 3'b001, 32'h001, 32'h0,        32'h0,        0, 1, 4'h0,    32'h0,        32'h0});
      tbl.push_back('{1, 0, 3'b101, 32'h006, 32'h0,        32'hBEEF0000, 0, 0, 4'hF,    32'h0,        32'h0000BEEF});

      repeat (3) @(negedge clk);
      chk("reset outputs", {26'b0, Stall, load_valid, misaligned, access_fault, bus_req, bus_we}, 32'h0);
      chk("reset bus_be", {28'b0, bus_be}, 32'h0);
      chk("reset load_data", load_data, 32'h0);
      reset_stages = 1'b0;
      @(negedge clk);

      foreach (tbl[i]) begin
         if (tbl[i].kind == 0) run_access(tbl[i]);
         else                  run_reject(tbl[i]);
      end

      // reset during a bus wait, then a late bus_ready
      Mem_read = 1'b1;
      funct3   = 3'b010;
      addr     = 32'h500;
      @(negedge clk);
      chk("abort bus_req up", {31'b0, bus_req}, 32'h1);
      @(negedge clk);
      reset_stages = 1'b1;
      Mem_read     = 1'b0;
      @(negedge clk);
      chk("abort outputs", {27'b0, Stall, load_valid, misaligned, access_fault, bus_req}, 32'h0);
      reset_stages = 1'b0;
      bus_ready    = 1'b1;
      bus_rdata    = 32'h11111111;
      @(negedge clk);
      chk("late ready ignored", {30'b0, load_valid, bus_req}, 32'h0);
      bus_ready = 1'b0;
      @(negedge clk);
      run_access('{1, 0, 3'b010, 32'h600, 32'h0, 32'h0BADF00D, 0, 0, 4'hF, 32'h0, 32'h0BADF00D});

`ifdef MEM_TIMEOUT_EN
      begin
         int n_req = 0;
         Mem_read = 1'b1;
         funct3   = 3'b010;
         addr     = 32'h700;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_req) n_req++;
            else break;
         end
         chk("timeout req cycles", n_req, 4);
         chk("timeout fault", {31'b0, access_fault}, 32'h1);
         chk("timeout load_valid", {31'b0, load_valid}, 32'h0);
         chk("timeout load_data", load_data, 32'h0);
         Mem_read = 1'b0;
         @(negedge clk);
         chk("timeout fault cleared", {31'b0, access_fault}, 32'h0);
         run_access('{0, 1, 3'b010, 32'h704, 32'h600DCAFE, 32'h0, 0, 0, 4'hF, 32'h600DCAFE, 32'h0});
      end
`endif

      repeat (2) @(negedge clk);
      chk("scoreboard drained", exp_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global time limit: got timeout expected completion");
      $fatal(1);
   end

endmodule
